// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALU op codes,
// ID-stage FSM encoding and control-bundle field order.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } id_state_e;

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

    localparam int    CTRL_W   = $bits(ctrl_t);
    localparam ctrl_t CTRL_NOP = '0;

    function automatic logic rt_is_src(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/id_ctrl_decode.sv
// Opcode to control-bundle decoder for the ID stage.
// Purely combinational; unknown opcodes yield all-zero control.
module id_ctrl_decode
    import mips_pkg::*;
(
    input  logic [5:0]        opcode_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              illegal_o
);

    ctrl_t c;

    always_comb begin
        c         = CTRL_NOP;
        illegal_o = 1'b0;
        unique case (opcode_i)
            OP_RTYPE: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
                c.aluop    = ALUOP_FUNCT;
            end
            OP_LW: begin
                c.alusrc   = 1'b1;
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
                c.memread  = 1'b1;
                c.aluop    = ALUOP_ADD;
            end
            OP_SW: begin
                c.alusrc   = 1'b1;
                c.memwrite = 1'b1;
                c.aluop    = ALUOP_ADD;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
                c.aluop  = ALUOP_SUB;
            end
            OP_ADDI: begin
                c.alusrc   = 1'b1;
                c.regwrite = 1'b1;
                c.aluop    = ALUOP_ADD;
            end
            default: illegal_o = 1'b1;
        endcase
    end

    assign ctrl_o = c;

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage with load-use stall and ID/EX register.
// Optional macro ID_PERF_CNT_EN adds saturating stall/flush counters.
module id_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifid_valid,
    input  logic [31:0]       ifid_instr,
    input  logic [31:0]       ifid_pc,
    output logic              id_ready,
    input  logic              ex_flush,
    output logic [RA_W-1:0]   rf_rn1,
    output logic [RA_W-1:0]   rf_rn2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic              idex_valid,
    output logic [31:0]       idex_pc,
    output logic [DATA_W-1:0] idex_rd1,
    output logic [DATA_W-1:0] idex_rd2,
    output logic [DATA_W-1:0] idex_imm,
    output logic [RA_W-1:0]   idex_rs,
    output logic [RA_W-1:0]   idex_rt,
    output logic [RA_W-1:0]   idex_rd,
    output logic              idex_regdst,
    output logic              idex_alusrc,
    output logic              idex_memtoreg,
    output logic              idex_regwrite,
    output logic              idex_memread,
    output logic              idex_memwrite,
    output logic              idex_branch,
    output logic [1:0]        idex_aluop,
`ifdef ID_PERF_CNT_EN
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt,
`endif
    output logic              idex_illegal
);

    id_state_e         state_q;
    logic              valid_q;
    logic [31:0]       pc_q;
    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] rd2_q;
    logic [DATA_W-1:0] imm_q;
    logic [RA_W-1:0]   rs_q;
    logic [RA_W-1:0]   rt_q;
    logic [RA_W-1:0]   rd_q;
    ctrl_t             ctrl_q;
    logic              illegal_q;

    logic [5:0]        opcode;
    logic [RA_W-1:0]   rs_d;
    logic [RA_W-1:0]   rt_d;
    logic [RA_W-1:0]   rd_d;
    logic [DATA_W-1:0] imm_d;
    logic [CTRL_W-1:0] dec_raw;
    ctrl_t             dec_ctrl;
    logic              dec_illegal;
    logic              hazard;
    logic              stall;
    logic              issue;

    assign opcode = ifid_instr[31:26];
    assign rs_d   = ifid_instr[21 +: RA_W];
    assign rt_d   = ifid_instr[16 +: RA_W];
    assign rd_d   = ifid_instr[11 +: RA_W];
    assign imm_d  = {{(DATA_W-16){ifid_instr[15]}}, ifid_instr[15:0]};

    id_ctrl_decode u_dec (
        .opcode_i  (opcode),
        .ctrl_o    (dec_raw),
        .illegal_o (dec_illegal)
    );

    assign dec_ctrl = ctrl_t'(dec_raw);

    // A load in EX whose target feeds this instruction must wait a cycle.
    always_comb begin
        hazard = ifid_valid && valid_q && ctrl_q.memread
              && (rt_q != '0)
              && ((rt_q == rs_d) || (rt_is_src(opcode) && (rt_q == rt_d)));
        stall  = (state_q == ST_RUN) && hazard && !ex_flush;
        issue  = ifid_valid && !ex_flush && !stall;
    end

    assign id_ready = !stall;
    assign rf_rn1   = rs_d;
    assign rf_rn2   = rt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            ctrl_q    <= CTRL_NOP;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= stall ? ST_BUBBLE : ST_RUN;
            valid_q   <= issue;
            ctrl_q    <= issue ? dec_ctrl : CTRL_NOP;
            illegal_q <= issue && dec_illegal;
            if (ifid_valid) begin
                pc_q  <= ifid_pc;
                rd1_q <= rf_rd1;
                rd2_q <= rf_rd2;
                imm_q <= imm_d;
                rs_q  <= rs_d;
                rt_q  <= rt_d;
                rd_q  <= rd_d;
            end
        end
    end

    assign idex_valid    = valid_q;
    assign idex_pc       = pc_q;
    assign idex_rd1      = rd1_q;
    assign idex_rd2      = rd2_q;
    assign idex_imm      = imm_q;
    assign idex_rs       = rs_q;
    assign idex_rt       = rt_q;
    assign idex_rd       = rd_q;
    assign idex_regdst   = ctrl_q.regdst;
    assign idex_alusrc   = ctrl_q.alusrc;
    assign idex_memtoreg = ctrl_q.memtoreg;
    assign idex_regwrite = ctrl_q.regwrite;
    assign idex_memread  = ctrl_q.memread;
    assign idex_memwrite = ctrl_q.memwrite;
    assign idex_branch   = ctrl_q.branch;
    assign idex_aluop    = ctrl_q.aluop;
    assign idex_illegal  = illegal_q;

`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (ex_flush && ifid_valid && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Randomized self-checking bench for id_stage against a
// table-driven reference model of the decode/stall rules.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifid_valid = 1'b0;
    logic [31:0] ifid_instr = '0;
    logic [31:0] ifid_pc = '0;
    logic        ex_flush = 1'b0;
    logic        id_ready;
    logic [4:0]  rf_rn1, rf_rn2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        idex_valid;
    logic [31:0] idex_pc, idex_rd1, idex_rd2, idex_imm;
    logic [4:0]  idex_rs, idex_rt, idex_rd;
    logic        idex_regdst, idex_alusrc, idex_memtoreg, idex_regwrite;
    logic        idex_memread, idex_memwrite, idex_branch, idex_illegal;
    logic [1:0]  idex_aluop;
`ifdef ID_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    logic [31:0] regs [32];
    assign rf_rd1 = regs[rf_rn1];
    assign rf_rd2 = regs[rf_rn2];

    always #5 clk = ~clk;

    id_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .id_ready      (id_ready),
        .ex_flush      (ex_flush),
        .rf_rn1        (rf_rn1),
        .rf_rn2        (rf_rn2),
        .rf_rd1        (rf_rd1),
        .rf_rd2        (rf_rd2),
        .idex_valid    (idex_valid),
        .idex_pc       (idex_pc),
        .idex_rd1      (idex_rd1),
        .idex_rd2      (idex_rd2),
        .idex_imm      (idex_imm),
        .idex_rs       (idex_rs),
        .idex_rt       (idex_rt),
        .idex_rd       (idex_rd),
        .idex_regdst   (idex_regdst),
        .idex_alusrc   (idex_alusrc),
        .idex_memtoreg (idex_memtoreg),
        .idex_regwrite (idex_regwrite),
        .idex_memread  (idex_memread),
        .idex_memwrite (idex_memwrite),
        .idex_branch   (idex_branch),
        .idex_aluop    (idex_aluop),
`ifdef ID_PERF_CNT_EN
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt),
`endif
        .idex_illegal  (idex_illegal)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model of the ID/EX contents.
    // ctrl bits: regdst alusrc memtoreg regwrite memread memwrite branch aluop[1:0] illegal
    logic        m_valid;
    logic [9:0]  m_ctrl;
    logic [31:0] m_pc, m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    int unsigned m_stalls, m_flushes;

    function automatic logic [9:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'h00:   return 10'b1001000_10_0;
            6'h23:   return 10'b0111100_00_0;
            6'h2B:   return 10'b0100010_00_0;
            6'h04:   return 10'b0000001_01_0;
            6'h08:   return 10'b0101000_00_0;
            default: return 10'b0000000_00_1;
        endcase
    endfunction

    function automatic logic reads_rt(input logic [5:0] op);
        return op == 6'h00 || op == 6'h2B || op == 6'h04;
    endfunction

    function automatic logic [9:0] dut_ctrl();
        return {idex_regdst, idex_alusrc, idex_memtoreg, idex_regwrite,
                idex_memread, idex_memwrite, idex_branch, idex_aluop,
                idex_illegal};
    endfunction

    task automatic check_perf();
`ifdef ID_PERF_CNT_EN
        chk("perf_stall", perf_stall_cnt, m_stalls);
        chk("perf_flush", perf_flush_cnt, m_flushes);
`endif
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(idex_valid), 32'd0);
        chk({tag, "_ctrl"}, 32'(dut_ctrl()), 32'd0);
        chk({tag, "_data"}, idex_pc | idex_rd1 | idex_rd2 | idex_imm
            | 32'({idex_rs, idex_rt, idex_rd}), 32'd0);
        chk({tag, "_ready"}, 32'(id_ready), 32'd1);
    endtask

    task automatic do_reset();
        ifid_valid = 1'b0;
        ex_flush   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        m_valid = 1'b0; m_ctrl = '0; m_stalls = 0; m_flushes = 0;
        check_zero("rst");
        check_perf();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
    endtask

    logic last_ready = 1'b1;

    task automatic step(input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic fl);
        logic haz, rdy, load;
        logic [5:0] op;
        ifid_valid = v; ifid_instr = ins; ifid_pc = pc; ex_flush = fl;
        op  = ins[31:26];
        haz = v && m_valid && m_ctrl[5] && m_rt != 0
           && (m_rt == ins[25:21] || (reads_rt(op) && m_rt == ins[20:16]));
        rdy  = !(haz && !fl);
        load = v && !fl && rdy;
        #1;
        chk("ready", 32'(id_ready), 32'(rdy));
        chk("rn1", 32'(rf_rn1), 32'(ins[25:21]));
        chk("rn2", 32'(rf_rn2), 32'(ins[20:16]));
        if (!rdy) m_stalls++;
        if (fl && v) m_flushes++;
        m_valid = load;
        m_ctrl  = load ? ref_ctrl(op) : 10'd0;
        if (load) begin
            m_pc  = pc;
            m_rd1 = regs[ins[25:21]];
            m_rd2 = regs[ins[20:16]];
            m_imm = {{16{ins[15]}}, ins[15:0]};
            m_rs  = ins[25:21];
            m_rt  = ins[20:16];
            m_rd  = ins[15:11];
        end
        @(posedge clk) #1;
        chk("valid", 32'(idex_valid), 32'(m_valid));
        chk("ctrl", 32'(dut_ctrl()), 32'(m_ctrl));
        if (m_valid) begin
            chk("pc", idex_pc, m_pc);
            chk("rd1", idex_rd1, m_rd1);
            chk("rd2", idex_rd2, m_rd2);
            chk("imm", idex_imm, m_imm);
            chk("rs", 32'(idex_rs), 32'(m_rs));
            chk("rt", 32'(idex_rt), 32'(m_rt));
            chk("rd", 32'(idex_rd), 32'(m_rd));
        end
        check_perf();
        last_ready = rdy;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [6];
        logic [5:0] op;
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B;
        ops[3] = 6'h04; ops[4] = 6'h08; ops[5] = 6'($urandom);
        op = ops[$urandom_range(5)];
        return {op, 5'($urandom_range(3)), 5'($urandom_range(3)),
                16'($urandom)};
    endfunction

    initial begin
        logic [31:0] ins, pc;
        logic v;
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 0 : $urandom;
        regs[1] = 5;
        regs[2] = 7;
        m_valid = 1'b0; m_ctrl = '0; m_stalls = 0; m_flushes = 0;
        m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
        m_rs = '0; m_rt = '0; m_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("init");
        do_reset();

        step(1, 32'h00221820, 32'h104, 0);
        chk("add_rd1", idex_rd1, 32'd5);
        chk("add_rd2", idex_rd2, 32'd7);
        chk("add_rd", 32'(idex_rd), 32'd3);

        step(1, 32'h8C220004, 32'h108, 0);
        step(1, 32'h00441820, 32'h10C, 0);
        chk("stall_bubble", 32'(idex_valid), 32'd0);
        step(1, 32'h00441820, 32'h10C, 0);
        chk("stall_rs", 32'(idex_rs), 32'd2);

        step(1, 32'h8C200000, 32'h110, 0);
        step(1, 32'h00041820, 32'h114, 0);
        step(1, 32'h8C220004, 32'h118, 0);
        step(1, 32'h20C5FFFF, 32'h11C, 0);
        chk("addi_imm", idex_imm, 32'hFFFFFFFF);

        step(1, 32'h8C220004, 32'h120, 0);
        step(1, 32'h00441820, 32'h124, 1);
        step(1, 32'h00221820, 32'h200, 0);

        step(1, 32'hFC000000, 32'h204, 0);
        chk("illegal", 32'(idex_illegal), 32'd1);
        step(0, 32'h00221820, 32'h208, 0);

        step(1, 32'h8C220004, 32'h20C, 0);
        step(1, 32'h00441820, 32'h210, 0);
`ifdef ID_PERF_CNT_EN
        chk("perf_two_stalls", perf_stall_cnt, 32'd2);
        chk("perf_one_flush", perf_flush_cnt, 32'd1);
`endif
        do_reset();

        ins = 32'h0; pc = 32'h400; v = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (last_ready) begin
                v   = ($urandom_range(7) != 0);
                ins = rand_instr();
                pc  = pc + 4;
            end
            step(v, ins, pc, $urandom_range(7) == 0);
            if (n == 200) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the scalar five-stage MIPS pipeline.
- Takes the IF/ID instruction and drives the register-file read addresses; the register file returns read data combinationally.
- Sign-extends the immediate, decodes control, and detects load-use hazards. Inserts one bubble per hazard.
- Registers everything into the ID/EX pipeline register consumed by the EX stage.

Parameters:
- DATA_W, 32, datapath and register width
- RA_W, 5, register address width

Ports:
- clk  in  1  pipeline clock; ID/EX register updates on posedge
- rst_n  in  1  asynchronous active-low reset
- ifid_valid  in  1  IF/ID holds a real instruction
- ifid_instr  in  32  instruction word
- ifid_pc  in  32  PC+4 of the instruction
- id_ready  out  1  ID accepts the instruction this cycle; 0 means IF and IF/ID must hold
- ex_flush  in  1  branch taken in EX; kill ID contents
- rf_rn1  out  RA_W  register-file read address port 1 = instr[25:21]
- rf_rn2  out  RA_W  register-file read address port 2 = instr[20:16]
- rf_rd1  in  DATA_W  read data port 1 (reg 0 reads 0)
- rf_rd2  in  DATA_W  read data port 2
- idex_valid  out  1  ID/EX holds a real instruction
- idex_pc  out  32  registered PC+4
- idex_rd1, idex_rd2  out  DATA_W  registered operands
- idex_imm  out  DATA_W  sign-extended instr[15:0]
- idex_rs, idex_rt, idex_rd  out  RA_W  register specifiers, for forwarding
- idex_regdst, idex_alusrc, idex_memtoreg, idex_regwrite, idex_memread, idex_memwrite, idex_branch  out  1 each  control
- idex_aluop  out  2  00 add, 01 sub, 10 funct-decoded
- idex_illegal  out  1  opcode not in supported set

Behaviour:
- Reset (rst_n=0, asynchronous): all idex_* outputs 0; FSM goes to RUN. id_ready is combinational; it is 1 after reset unless a hazard condition holds.
- Supported opcodes:
  - R-type 0x00: regdst=1, regwrite=1, aluop=10.
  - lw 0x23: alusrc=1, memtoreg=1, regwrite=1, memread=1, aluop=00.
  - sw 0x2B: alusrc=1, memwrite=1, aluop=00.
  - beq 0x04: branch=1, aluop=01.
  - addi 0x08: alusrc=1, regwrite=1, aluop=00.
  - Any other opcode: all control 0 and illegal=1.
- rt is a source for R-type, sw and beq only.
- Load-use hazard (combinational) requires all of:
  - ifid_valid and idex_valid and idex_memread.
  - idex_rt != 0.
  - idex_rt == instr[25:21], or (rt is a source and idex_rt == instr[20:16]).
- FSM states: RUN and BUBBLE.
  - RUN with hazard and no ex_flush: id_ready=0, ID/EX loads a bubble (valid=0, all control 0), go to BUBBLE.
  - BUBBLE: the hazard cannot re-fire because idex_memread=0. id_ready=1, the instruction is decoded normally, return to RUN.
- Latency: one cycle from IF/ID to ID/EX.
- Register-file timing: writeback happens on negedge, so same-cycle WB data is already visible on rf_rd*. No WB bypass in this block.
- Precedence is ex_flush > hazard > normal:
  - ex_flush=1: ID/EX loads a bubble, FSM goes to RUN, id_ready=1 (IF is redirected and the IF/ID contents are discarded).
  - Simultaneous flush and hazard: treated as a flush, no stall.
- ifid_valid=0: ID/EX loads a bubble, id_ready=1, no hazard.
- Bubble rule: registered data fields may keep stale values but idex_valid=0 and all control outputs must be 0.
- Reset mid-stall: everything returns immediately to the reset values above.

Optional Feature:
- Macro ID_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_stall_cnt (32): increments each hazard-bubble cycle.
  - perf_flush_cnt (32): increments each cycle ex_flush=1 with ifid_valid=1.
- Both counters are reset to 0 by rst_n and saturate at 0xFFFFFFFF.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI;
  - ALUOP_ADD/SUB/FUNCT;
  - the FSM state encoding;
  - the control-bundle field order.
- One combinational sub-module, id_ctrl_decode: opcode to control bundle plus illegal flag. The hazard logic, FSM and ID/EX register stay in id_stage.

Test Plan:
- Reset and basic decode:
  - Stimulus: assert rst_n=0 mid-cycle, release; send add $3,$1,$2 (0x00221820) with rf_rd1=5, rf_rd2=7.
  - Response: after reset all idex_*=0; next posedge idex_rd1=5, idex_rd2=7, idex_rd=3, regdst=1, regwrite=1, aluop=10, valid=1.
- Load-use stall:
  - Stimulus: lw $2,4($1) (0x8C220004) followed by add $3,$2,$4.
  - Response: id_ready=0 for exactly one cycle; ID/EX shows valid=0; the add is then issued with idex_rs=2.
- No false stall:
  - Stimulus: lw $0,0($1) then add $3,$0,$4; separately, lw $2 then addi $5,$6,-1 (rt unused as a source).
  - Response: no stall in either case; idex_imm=0xFFFFFFFF for the addi.
- Flush during hazard:
  - Stimulus: the lw/add hazard with ex_flush=1 in the hazard cycle.
  - Response: ID/EX bubble, id_ready=1, FSM in RUN, no extra bubble the following cycle.
- Illegal and invalid:
  - Stimulus: opcode 0x3F; then ifid_valid=0.
  - Response: illegal=1 with all control 0; then valid=0.
  - With ID_PERF_CNT_EN: after two hazards and one flush, perf_stall_cnt=2 and perf_flush_cnt=1.
